// File: rtl/sigproc_pkg.sv
// Shared types and sample-arithmetic helpers for the echo mixer.
package sigproc_pkg;

  typedef enum logic [1:0] {FILL, FADE, RUN} mix_state_t;

  // Full wet gain; g is in eighths, so G_MAX means unity.
  localparam int unsigned G_MAX = 8;
  localparam int unsigned G_W   = 4;

  // Offset binary -> signed. Subtracting mid-scale is the same as inverting the MSB,
  // but yields a properly sign-extended 32-bit result.
  function automatic logic signed [31:0] to_signed_ob(input logic [31:0] x,
                                                      input int unsigned w);
    logic signed [31:0] mid;
    mid = signed'(32'd1 << (w - 1));
    return signed'(x) - mid;
  endfunction

  // Signed -> offset binary; only the low w bits are meaningful.
  function automatic logic [31:0] to_offset_ob(input logic signed [31:0] s,
                                               input int unsigned w);
    logic signed [31:0] mid;
    mid = signed'(32'd1 << (w - 1));
    return unsigned'(s + mid);
  endfunction

  // Add and clamp to the signed range of a w-bit sample.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned w);
    logic signed [31:0] sum, hi, lo;
    hi  = signed'((32'd1 << (w - 1)) - 32'd1);
    lo  = -hi - 32'sd1;
    sum = a + b;
    if (sum > hi) begin
      return hi;
    end else if (sum < lo) begin
      return lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/echo_mixer_if.sv
// Sample stream bundle between the delay block and the echo mixer.
interface echo_mixer_if #(
  parameter int unsigned D_WIDTH = 8
);
  logic               en;
  logic [D_WIDTH-1:0] dry;
  logic [D_WIDTH-1:0] wet;
  logic [2:0]         atten;
  logic               mute;
  logic [D_WIDTH-1:0] mix;
  logic               mix_valid;
  logic               primed;

  modport master (
    output en, dry, wet, atten, mute,
    input  mix, mix_valid, primed
  );

  modport slave (
    input  en, dry, wet, atten, mute,
    output mix, mix_valid, primed
  );
endinterface

// File: rtl/mix_fade_ctrl.sv
// Wet-gain sequencer: waits for the delay RAM to fill, then ramps g from 0 up to G_MAX.
module mix_fade_ctrl
  import sigproc_pkg::*;
#(
  parameter int unsigned FILL_LEN  = 256,
  parameter int unsigned FADE_LOG2 = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           mute,
  output logic [G_W-1:0] g,
  output logic           primed
);

  localparam int unsigned      FillW    = $clog2(FILL_LEN + 1);
  localparam int unsigned      FadeW    = (FADE_LOG2 > 0) ? FADE_LOG2 : 1;
  localparam logic [FillW-1:0] FillLast = FillW'(FILL_LEN - 1);
  localparam logic [FillW-1:0] FillSat  = FillW'(FILL_LEN);
  localparam logic [G_W-1:0]   GLast    = G_W'(G_MAX - 1);
  localparam logic [G_W-1:0]   GFull    = G_W'(G_MAX);

  mix_state_t       state_q, state_d;
  logic [FillW-1:0] fill_cnt_q, fill_cnt_d;
  logic [FadeW-1:0] fade_cnt_q, fade_cnt_d;
  logic [G_W-1:0]   g_q, g_d;
  logic             primed_q, primed_d;
  logic             fade_step;

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      fill_cnt_q <= '0;
      fade_cnt_q <= '0;
      g_q        <= '0;
      primed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      fade_cnt_q <= fade_cnt_d;
      g_q        <= g_d;
      primed_q   <= primed_d;
    end
  end

  // Next state: advance on strobes only; mute overrides the gain path at any time
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    fade_cnt_d = fade_cnt_q;
    g_d        = g_q;
    primed_d   = primed_q;
    // g steps on the first strobe of each fade period, so fade-in audibly starts at once
    fade_step  = (FADE_LOG2 == 0) || (fade_cnt_q == '0);

    if (en) begin
      unique case (state_q)
        FILL: begin
          g_d = '0;
          if (fill_cnt_q == FillLast) begin
            state_d    = FADE;
            primed_d   = 1'b1;
            fill_cnt_d = FillSat;
          end else begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
        end
        FADE: begin
          fade_cnt_d = fade_cnt_q + 1'b1;
          if (fade_step) begin
            g_d = g_q + 1'b1;
            if (g_q == GLast) begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          g_d = GFull;
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end

    if (mute) begin
      g_d        = '0;
      fade_cnt_d = '0;
      if (state_d != FILL) begin
        state_d = FADE;
      end
    end
  end

  // Outputs straight from registers
  always_comb begin
    g      = g_q;
    primed = primed_q;
  end

endmodule

// File: rtl/echo_mixer.sv
// Two-stage dry/wet echo mixer with saturating offset-binary output.
module echo_mixer
  import sigproc_pkg::*;
#(
  parameter int unsigned D_WIDTH   = 8,
  parameter int unsigned FILL_LEN  = 256,
  parameter int unsigned FADE_LOG2 = 4
) (
  input logic         clk,
  input logic         rst,
  echo_mixer_if.slave bus
);

  localparam logic [D_WIDTH-1:0] Mid = {1'b1, {(D_WIDTH-1){1'b0}}};

  logic [G_W-1:0]           g;
  logic                     primed;
  logic                     v1_q;
  logic [D_WIDTH-1:0]       dry_q;
  logic [D_WIDTH-1:0]       mix_q, mix_d;
  logic                     mix_valid_q;
  logic signed [31:0]       dry_s, wet_s, sum;
  logic [31:0]              mix_ob;
  logic signed [D_WIDTH+3:0] wet_n, g_n, prod, wet_t;
  logic                     unused_hi;

  mix_fade_ctrl #(
    .FILL_LEN (FILL_LEN),
    .FADE_LOG2(FADE_LOG2)
  ) u_ctrl (
    .clk   (clk),
    .rst   (rst),
    .en    (bus.en),
    .mute  (bus.mute),
    .g     (g),
    .primed(primed)
  );

  // Stage 1: capture dry with the strobe; wet shows up from the RAM one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      dry_q <= '0;
    end else begin
      v1_q <= bus.en;
      if (bus.en) begin
        dry_q <= bus.dry;
      end
    end
  end

  // Stage-2 arithmetic: scale wet by g/8, attenuate, add to dry, saturate
  always_comb begin
    dry_s     = to_signed_ob(32'(dry_q), D_WIDTH);
    wet_s     = to_signed_ob(32'(bus.wet), D_WIDTH);
    wet_n     = wet_s[D_WIDTH+3:0];
    g_n       = {{D_WIDTH{1'b0}}, g};
    prod      = wet_n * g_n;
    wet_t     = (prod >>> 3) >>> bus.atten;
    if (bus.mute) begin
      wet_t = '0;
    end
    sum       = sat_add(dry_s, 32'(wet_t), D_WIDTH);
    mix_ob    = to_offset_ob(sum, D_WIDTH);
    mix_d     = mix_ob[D_WIDTH-1:0];
    unused_hi = ^{mix_ob[31:D_WIDTH], wet_s[31:D_WIDTH+4]};
  end

  // Stage 2 register: mix holds between pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      mix_q       <= Mid;
      mix_valid_q <= 1'b0;
    end else begin
      mix_valid_q <= v1_q;
      if (v1_q) begin
        mix_q <= mix_d;
      end
    end
  end

  assign bus.mix       = mix_q;
  assign bus.mix_valid = mix_valid_q;
  assign bus.primed    = primed;

endmodule

// File: tb/tb_echo_mixer.sv
// Randomized bench for echo_mixer with a behavioural reference model.
module tb_echo_mixer;

  localparam int DW   = 8;
  localparam int FL   = 4;
  localparam int FL2  = 1;
  localparam int PER  = 1 << FL2;
  localparam int KMAX = 8 * PER;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   chk_en   = 0;
  logic [7:0] wet_pend = 8'h00;

  echo_mixer_if #(.D_WIDTH(DW)) bus ();

  echo_mixer #(
    .D_WIDTH  (DW),
    .FILL_LEN (FL),
    .FADE_LOG2(FL2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int fdiv(input int x, input int n);
    if (x >= 0) return x / n;
    return -((-x + n - 1) / n);
  endfunction

  function automatic int ref_mix(input int d, input int w, input int g, input bit m,
                                 input int a);
    int ds, ws, wt, s;
    ds = d - 128;
    ws = w - 128;
    wt = m ? 0 : fdiv(ws * g, 8 * (1 << a));
    s  = ds + wt;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s + 128;
  endfunction

  int m_fill, m_k, m_mix, p_dry;
  bit m_valid, p_valid;

  // Gain implied by the strobe history: 0 while filling, then one step per period
  function automatic int cur_g(input int fill, input int k);
    int gg;
    if (fill < FL) return 0;
    gg = (k + PER - 1) / PER;
    return (gg > 8) ? 8 : gg;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_mix   <= 128;
      m_fill  <= 0;
      m_k     <= 0;
      p_valid <= 1'b0;
    end else begin
      m_valid <= p_valid;
      if (p_valid) m_mix <= ref_mix(p_dry, int'(bus.wet), cur_g(m_fill, m_k), bus.mute,
                                    int'(bus.atten));
      p_valid <= bus.en;
      if (bus.en) p_dry <= int'(bus.dry);
      if (bus.mute) m_k <= 0;
      else if (bus.en && m_fill >= FL && m_k < KMAX) m_k <= m_k + 1;
      if (bus.en && m_fill < FL) m_fill <= m_fill + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", 32'(bus.mix_valid), 32'(m_valid));
      check("mix", 32'(bus.mix), 32'(m_mix));
      check("primed", 32'(bus.primed), 32'(m_fill >= FL));
    end
  end

  // One cycle of stimulus, called at a negedge; w is the RAM word for this strobe
  task automatic step(input logic e, input logic [7:0] d, input logic [7:0] w);
    bus.wet  = wet_pend;
    bus.en   = e;
    bus.dry  = d;
    wet_pend = w;
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    bus.en    = 1'b0;
    bus.dry   = 8'h00;
    bus.wet   = 8'h00;
    bus.atten = 3'd0;
    bus.mute  = 1'b0;

    // Reset, with strobes during reset
    step(1'b1, 8'h55, 8'h33);
    step(1'b1, 8'h66, 8'h44);
    chk_en = 1;
    check("rst_mix", 32'(bus.mix), 32'h80);
    check("rst_valid", 32'(bus.mix_valid), 32'h0);
    check("rst_primed", 32'(bus.primed), 32'h0);
    rst = 1'b0;
    step(1'b0, 8'h00, 8'h00);
    check("rst_flush", 32'(bus.mix_valid), 32'h0);

    // Fill: wet gated off
    for (int i = 0; i < 3; i++) step(1'b1, 8'hA0, 8'hFF);
    check("fill_primed_lo", 32'(bus.primed), 32'h0);
    step(1'b1, 8'hA0, 8'hFF);
    check("fill_primed_hi", 32'(bus.primed), 32'h1);
    step(1'b0, 8'h00, 8'h00);
    check("fill_mix", 32'(bus.mix), 32'hA0);

    // Fade-in to RUN
    for (int i = 0; i < 18; i++) begin
      int gexp;
      gexp = (i + 2) / 2;
      if (gexp > 8) gexp = 8;
      step(1'b1, 8'h80, 8'hC0);
      step(1'b0, 8'h00, 8'h00);
      check("fade_mix", 32'(bus.mix), 32'(8'h80 + 8 * gexp));
    end

    // Saturation with back-to-back strobes
    step(1'b1, 8'hF0, 8'hF0);
    step(1'b1, 8'h10, 8'h10);
    check("sat_hi", 32'(bus.mix), 32'hFF);
    step(1'b0, 8'h00, 8'h00);
    check("sat_lo", 32'(bus.mix), 32'h00);
    check("b2b_valid", 32'(bus.mix_valid), 32'h1);
    step(1'b0, 8'h00, 8'h00);

    // Attenuation
    bus.atten = 3'd2;
    step(1'b1, 8'h80, 8'h00);
    step(1'b0, 8'h00, 8'h00);
    check("atten2", 32'(bus.mix), 32'h60);
    bus.atten = 3'd7;
    step(1'b1, 8'h80, 8'h00);
    step(1'b0, 8'h00, 8'h00);
    check("atten7", 32'(bus.mix), 32'h7F);
    bus.atten = 3'd0;

    // Mute in RUN, release restarts fade, reset mid-fade
    bus.mute = 1'b1;
    step(1'b1, 8'h30, 8'hF0);
    step(1'b0, 8'h00, 8'h00);
    check("mute_dry", 32'(bus.mix), 32'h30);
    bus.mute = 1'b0;
    step(1'b1, 8'h80, 8'hC0);
    step(1'b0, 8'h00, 8'h00);
    check("unmute_g1", 32'(bus.mix), 32'h88);
    check("unmute_primed", 32'(bus.primed), 32'h1);
    step(1'b1, 8'h80, 8'hC0);
    rst = 1'b1;
    step(1'b0, 8'h00, 8'h00);
    rst = 1'b0;
    check("rst_fade_mix", 32'(bus.mix), 32'h80);
    check("rst_fade_primed", 32'(bus.primed), 32'h0);
    step(1'b0, 8'h00, 8'h00);
    check("rst_fade_valid", 32'(bus.mix_valid), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) bus.mute = ~bus.mute;
      if ($urandom_range(0, 19) == 0) bus.atten = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 299) == 0);
      step($urandom_range(0, 9) < 6, 8'($urandom), 8'($urandom));
    end
    rst      = 1'b0;
    bus.mute = 1'b0;
    step(1'b0, 8'h00, 8'h00);
    step(1'b0, 8'h00, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
